sub16_seq: RTL

Sequential 16-bit two's-complement subtractor, the subtract-side counterpart to the team's registered 16-bit look-ahead adder. Computes `in1 - in2` as `in1 + ~in2 + 1` through one 4-bit look-ahead slice, one nibble per clock, with a start/busy/done handshake. Registered difference, borrow and signed-overflow flags are held until the next completed operation. Sits in the datapath wherever a low-area subtract with flag outputs is acceptable at 4-cycle latency.

---
 rtl/sub16_pkg.sv | 22 ++
 rtl/sub16_seq_cla4.sv | 33 +++
 rtl/sub16_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sub16_pkg.sv
// rtl/sub16_pkg.sv - shared types and constants for the sequential 16-bit subtractor
//
// Purpose : FSM state enum, datapath widths and saturation constants used by
//           sub16_seq and its look-ahead slice.
// Ports   : none (package).
// Config  : SUB16_SAT_EN (consumed by sub16_seq) selects the saturating result.
package sub16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/sub16_seq_cla4.sv
// rtl/sub16_seq_cla4.sv - 4-bit carry look-ahead adder slice
//
// Purpose : single-cycle 4-bit add with flattened look-ahead carries.
// Ports   : a[3:0], b[3:0], cin  -> sum[3:0], cout
module cla4
  import sub16_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expressed directly in terms of g/p/cin, no ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/sub16_seq.sv
// rtl/sub16_seq.sv - sequential 16-bit subtractor, one nibble per clock
//
// Purpose : diffout = in1 - in2 computed as in1 + ~in2 + 1 through one cla4
//           slice over four CALC cycles, with registered borrow/overflow flags.
// Ports   : clk, reset (async, active-low), start, in1[15:0], in2[15:0]
//           -> diffout[15:0], borrow, overf, busy, done
// Config  : define SUB16_SAT_EN to saturate diffout on signed overflow.
module sub16_seq
  import sub16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] diffout,
  output logic             borrow,
  output logic             overf,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bn_q, bn_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             overf_q, overf_d;
  logic             ovf;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  assign slice_a = a_q[{cnt_q, 2'b00} +: SLICE];
  assign slice_b = bn_q[{cnt_q, 2'b00} +: SLICE];

  cla4 u_cla4 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    bn_d     = bn_q;
    part_d   = part_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    overf_d  = overf_q;
    ovf      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = in1;
          bn_d    = ~in2;
          carry_d = 1'b1;   // the +1 of the two's-complement negation
          cnt_d   = 2'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        part_d[{cnt_q, 2'b00} +: SLICE] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'(NSLICE - 1)) begin
          // ~bn_q[15] recovers in2[15]; overflow when operand signs differ and
          // the result sign differs from the minuend.
          ovf      = (a_q[WIDTH-1] ^ ~bn_q[WIDTH-1]) & (a_q[WIDTH-1] ^ part_d[WIDTH-1]);
          diff_d   = part_d;
          borrow_d = ~slice_cout;
          overf_d  = ovf;
`ifdef SUB16_SAT_EN
          if (ovf) begin
            diff_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
`endif
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      a_q      <= '0;
      bn_q     <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      overf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      bn_q     <= bn_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      overf_q  <= overf_d;
    end
  end

  assign diffout = diff_q;
  assign borrow  = borrow_q;
  assign overf   = overf_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);

endmodule
